// File: rtl/jtkiwi_tile_scan_pkg.sv
// Shared constants and types for the line-buffer scan block.
package jtkiwi_scan_pkg;

  localparam int PXL_W  = 9;
  localparam int ADDR_W = 9;

  // Pixel code that marks a transparent draw write.
  localparam logic [3:0] TRANSP_CODE = 4'd0;

  // Scan sequencer: read one location, then clear it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_CLR  = 2'd2
  } scan_st_e;

endpackage

// File: rtl/jtframe_dpram.sv
// Simple dual-port RAM: port A write-only (fill), port B read/write (scan/clear).
// Contents are not initialised; port B read data is registered.
module jtframe_dpram #(
  parameter int DW = 9,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic [AW-1:0] i_addr_a,
  input  logic [DW-1:0] i_data_a,
  input  logic          i_we_a,
  input  logic [AW-1:0] i_addr_b,
  input  logic [DW-1:0] i_data_b,
  input  logic          i_we_b,
  output logic [DW-1:0] o_q_b
);

  logic [DW-1:0] r_mem [2**AW];

  // Both write ports plus the registered port-B read.
  always_ff @(posedge clk) begin
    if (i_we_a) r_mem[i_addr_a] <= i_data_a;
    if (i_we_b) r_mem[i_addr_b] <= i_data_b;
    o_q_b <= r_mem[i_addr_b];
  end

endmodule

// File: rtl/jtkiwi_tile_scan.sv
// Double-buffered line buffer. The draw side fills one bank while the scan
// side reads the other and clears each location right after reading it, so
// a bank is empty again by the time it becomes the fill bank.
//
// Scan protocol: pxl_cen is a single-cycle request sampled only in ST_IDLE;
// hdump/flip must stay stable through the following READ cycle, and pxl
// carries the result from two clocks after the request edge until the next
// result. Requests arriving in READ or CLR are ignored.
module jtkiwi_tile_scan
  import jtkiwi_scan_pkg::*;
#(
  parameter logic [8:0] HOFFSET = 9'd0,
  parameter logic       TRANSP  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pxl_cen,
  input  logic              hs,
  input  logic [ADDR_W-1:0] hdump,
  input  logic              flip,
  input  logic [ADDR_W-1:0] buf_addr,
  input  logic              buf_we,
  input  logic [PXL_W-1:0]  buf_din,
  output logic              line_start,
  output logic [PXL_W-1:0]  pxl,
  output scan_st_e          dbg_state
);

  scan_st_e            r_state;
  scan_st_e            w_next;
  logic                r_hs_l;
  logic                r_bsel;      // fill bank id; scan bank is ~r_bsel
  logic                r_swap_d;
  logic                r_line_start;
  logic                r_rd_bank;   // bank the in-flight read/clear targets
  logic [ADDR_W-1:0]   r_clr_addr;
  logic [PXL_W-1:0]    r_pxl;

  logic                w_hs_rise;
  logic [ADDR_W-1:0]   w_sum;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [ADDR_W-1:0]   w_addr_b;
  logic                w_wr_ok;
  logic [1:0]          w_we_a;
  logic [1:0]          w_we_b;
  logic [PXL_W-1:0]    w_q0;
  logic [PXL_W-1:0]    w_q1;
  logic [PXL_W-1:0]    w_q;

  assign w_hs_rise = hs & ~r_hs_l;
  assign w_sum     = hdump + HOFFSET;
  assign w_rd_addr = flip ? ~w_sum : w_sum;
  assign w_addr_b  = (r_state == ST_CLR) ? r_clr_addr : w_rd_addr;

  // Transparent pixels never overwrite what is already in the fill bank.
  assign w_wr_ok = rst_n & buf_we & ~(TRANSP & (buf_din[3:0] == TRANSP_CODE));
  assign w_we_a  = {w_wr_ok & r_bsel, w_wr_ok & ~r_bsel};
  assign w_we_b  = {(r_state == ST_CLR) &  r_rd_bank,
                    (r_state == ST_CLR) & ~r_rd_bank};
  assign w_q     = r_rd_bank ? w_q1 : w_q0;

  assign line_start = r_line_start;
  assign pxl        = r_pxl;
  assign dbg_state  = r_state;

  // Line boundary: swap banks on hs rising edge, announce it one clock later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_l       <= 1'b0;
      r_bsel       <= 1'b0;
      r_swap_d     <= 1'b0;
      r_line_start <= 1'b0;
    end else begin
      r_hs_l       <= hs;
      r_swap_d     <= w_hs_rise;
      r_line_start <= r_swap_d;
      if (w_hs_rise) r_bsel <= ~r_bsel;
    end
  end

  // Scan sequencer state plus the per-read bank/address/pixel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rd_bank  <= 1'b0;
      r_clr_addr <= '0;
      r_pxl      <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_READ) begin
        r_rd_bank  <= ~r_bsel;
        r_clr_addr <= w_rd_addr;
      end
      if (r_state == ST_CLR) r_pxl <= w_q;
    end
  end

  // Next-state logic: IDLE -> READ on pxl_cen, then CLR, then back to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (pxl_cen) w_next = ST_READ;
      ST_READ: w_next = ST_CLR;
      ST_CLR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  jtframe_dpram #(.DW(PXL_W), .AW(ADDR_W)) u_bank0 (
    .clk      (clk),
    .i_addr_a (buf_addr),
    .i_data_a (buf_din),
    .i_we_a   (w_we_a[0]),
    .i_addr_b (w_addr_b),
    .i_data_b ('0),
    .i_we_b   (w_we_b[0]),
    .o_q_b    (w_q0)
  );

  jtframe_dpram #(.DW(PXL_W), .AW(ADDR_W)) u_bank1 (
    .clk      (clk),
    .i_addr_a (buf_addr),
    .i_data_a (buf_din),
    .i_we_a   (w_we_a[1]),
    .i_addr_b (w_addr_b),
    .i_data_b ('0),
    .i_we_b   (w_we_b[1]),
    .o_q_b    (w_q1)
  );

endmodule
